message_build_param: RTL and testbench

MESSAGE_BUILD_PARAM -- requirements
Module: message_build_param

---
 rtl/message_build_param.sv | 210 +++++++++++++++++++++
 tb/tb_message_build_param.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_build_param.sv
// Message padding block builder for SHA-2 style hashing.
// Accepts a per-message configuration (length, scheme, last flag), then
// streams the message blocks through a one-deep output register. The final
// block gets the 1-bit pad and big-endian length field. An extra block is
// emitted when the pad and length do not fit in the final block.
module message_build_param #(
  parameter int BLOCK_W = 512,
  parameter int LEN_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  input  logic               data_in_last,
  input  logic [LEN_W-1:0]   cfg_size,
  input  logic [1:0]         cfg_scheme,
  input  logic               cfg_last,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               data_out_last,
  output logic               err_last,
  output logic               done
);

  localparam int BLK_LOG = $clog2(BLOCK_W);
  // Largest remainder that still leaves room for the pad bit and length field.
  localparam int THR = BLOCK_W - LEN_W - 1;
  localparam logic [BLK_LOG-1:0] THR_R   = BLK_LOG'(THR);
  localparam logic [LEN_W-1:0]   ONE     = LEN_W'(1);
  localparam logic [BLOCK_W-1:0] TOP_BIT = {1'b1, {(BLOCK_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DATA, EXTRA} state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     size_q;
  logic [1:0]           scheme_q;
  logic                 cfg_last_q;
  logic [LEN_W-1:0]     nblk_q;
  logic [BLK_LOG-1:0]   rem_q;
  logic [LEN_W-1:0]     idx_q;

  logic [BLOCK_W-1:0]   data_p1;
  logic                 vld_p1;
  logic                 last_p1;
  logic                 tag_p1;
  logic                 err_p1;
  logic                 done_p1;

  logic                 cfg_hs, in_hs, out_hs, out_free;
  logic                 is_final, rem_zero, rem_fits, load_extra;
  logic [BLK_LOG-1:0]   cfg_rem;
  logic [LEN_W-1:0]     cfg_nblk;
  logic [BLOCK_W-1:0]   out_d;
  logic                 last_d;

  // Final block: keep the top r message bits, set the pad bit just below
  // them, clear the rest and optionally insert the length field.
  function automatic logic [BLOCK_W-1:0] pad_final(
    input logic [BLOCK_W-1:0] blk,
    input logic [BLK_LOG-1:0] r,
    input logic               add_len,
    input logic [LEN_W-1:0]   len
  );
    logic [BLOCK_W-1:0] keep;
    logic [BLOCK_W-1:0] res;
    keep = ~({BLOCK_W{1'b1}} >> r);
    res  = (blk & keep) | (TOP_BIT >> r);
    if (add_len) res[LEN_W-1:0] = len;
    return res;
  endfunction

  // Extra block: optional leading pad bit (when the message ended on a block
  // boundary or was empty), zeros, then the length field.
  function automatic logic [BLOCK_W-1:0] extra_block(
    input logic             with_pad,
    input logic [LEN_W-1:0] len
  );
    logic [BLOCK_W-1:0] res;
    res = with_pad ? TOP_BIT : '0;
    res[LEN_W-1:0] = len;
    return res;
  endfunction

  assign cfg_rem  = cfg_size[BLK_LOG-1:0];
  assign cfg_nblk = (cfg_size >> BLK_LOG) + {{(LEN_W-1){1'b0}}, |cfg_rem};
  assign cfg_hs   = cfg_valid && cfg_ready;
  assign in_hs    = data_in_valid && data_in_ready;
  assign out_hs   = vld_p1 && data_out_ready;
  assign out_free = !vld_p1 || data_out_ready;
  assign is_final = (idx_q == nblk_q - ONE);
  assign rem_zero = (rem_q == '0);
  assign rem_fits = (rem_q <= THR_R);

  // Next state and handshake readiness.
  always_comb begin
    state_d       = state_q;
    cfg_ready     = 1'b0;
    data_in_ready = 1'b0;
    load_extra    = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = !rst;
        if (cfg_hs) begin
          if (cfg_nblk != '0)         state_d = DATA;
          else if (cfg_scheme != 2'd1) state_d = EXTRA;
          else                         state_d = IDLE;
        end
      end
      DATA: begin
        data_in_ready = out_free && !rst;
        if (in_hs && is_final) begin
          if (scheme_q == 2'd1)          state_d = IDLE;
          else if (rem_zero || !rem_fits) state_d = EXTRA;
          else                            state_d = IDLE;
        end
      end
      EXTRA: begin
        if (out_free) begin
          load_extra = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Block to load into the output register this cycle.
  always_comb begin
    out_d  = data_in;
    last_d = 1'b0;
    if (load_extra) begin
      out_d  = extra_block(rem_zero, size_q);
      last_d = 1'b1;
    end else if (is_final) begin
      if (scheme_q == 2'd1) begin
        last_d = 1'b1;
      end else if (rem_zero) begin
        last_d = 1'b0;
      end else if (rem_fits) begin
        out_d  = pad_final(data_in, rem_q, 1'b1, size_q);
        last_d = 1'b1;
      end else begin
        out_d  = pad_final(data_in, rem_q, 1'b0, size_q);
        last_d = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Per-message configuration and block counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q     <= '0;
      scheme_q   <= '0;
      cfg_last_q <= 1'b0;
      nblk_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
    end else if (cfg_hs) begin
      size_q     <= cfg_size;
      scheme_q   <= cfg_scheme;
      cfg_last_q <= cfg_last;
      nblk_q     <= cfg_nblk;
      rem_q      <= cfg_rem;
      idx_q      <= '0;
    end else if (in_hs) begin
      idx_q      <= idx_q + ONE;
    end
  end

  // Output stage: one-deep register holding the block until accepted;
  // the done tag travels with the block so a new cfg cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      tag_p1  <= 1'b0;
      err_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      if (in_hs || load_extra) begin
        data_p1 <= out_d;
        last_p1 <= last_d;
        tag_p1  <= cfg_last_q;
        vld_p1  <= 1'b1;
      end else if (data_out_ready) begin
        vld_p1  <= 1'b0;
      end
      err_p1  <= in_hs && (data_in_last != is_final);
      done_p1 <= out_hs && last_p1 && tag_p1;
    end
  end

  assign data_out       = data_p1;
  assign data_out_valid = vld_p1;
  assign data_out_last  = last_p1;
  assign err_last       = err_p1;
  assign done           = done_p1;

endmodule

// File: tb/tb_message_build_param.sv
// Directed bench for message_build_param at 512-bit and 1024-bit widths.
module tb_message_build_param;

  localparam int BW  = 512;
  localparam int LW  = 64;
  localparam int BW2 = 1024;
  localparam int LW2 = 128;

  logic clk, rst;

  logic [BW-1:0]  din;
  logic           din_v, din_rdy, din_l;
  logic [LW-1:0]  csize;
  logic [1:0]     cscheme;
  logic           clast, cv, crdy;
  logic [BW-1:0]  dout;
  logic           dout_v, dout_rdy, dout_l, err, dn;

  logic [BW2-1:0] w_din;
  logic           w_din_v, w_din_rdy, w_din_l;
  logic [LW2-1:0] w_csize;
  logic [1:0]     w_cscheme;
  logic           w_clast, w_cv, w_crdy;
  logic [BW2-1:0] w_dout;
  logic           w_dout_v, w_dout_rdy, w_dout_l, w_err, w_dn;

  int checks = 0;
  int errors = 0;
  bit to_flag = 0;
  int err_cnt = 0, done_cnt = 0, in_cnt = 0;
  int w_err_cnt = 0, w_done_cnt = 0;

  logic [BW-1:0]  q_data[$];
  logic           q_last[$];
  logic [BW2-1:0] w_data[$];
  logic           w_last[$];

  message_build_param #(.BLOCK_W(BW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(din_v), .data_in_ready(din_rdy), .data_in_last(din_l),
    .cfg_size(csize), .cfg_scheme(cscheme), .cfg_last(clast), .cfg_valid(cv), .cfg_ready(crdy),
    .data_out(dout), .data_out_valid(dout_v), .data_out_ready(dout_rdy), .data_out_last(dout_l),
    .err_last(err), .done(dn)
  );

  message_build_param #(.BLOCK_W(BW2), .LEN_W(LW2)) dut_w (
    .clk(clk), .rst(rst),
    .data_in(w_din), .data_in_valid(w_din_v), .data_in_ready(w_din_rdy), .data_in_last(w_din_l),
    .cfg_size(w_csize), .cfg_scheme(w_cscheme), .cfg_last(w_clast), .cfg_valid(w_cv), .cfg_ready(w_crdy),
    .data_out(w_dout), .data_out_valid(w_dout_v), .data_out_ready(w_dout_rdy), .data_out_last(w_dout_l),
    .err_last(w_err), .done(w_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge; this monitor samples on negedge.
  always @(negedge clk) begin
    if (dout_v && dout_rdy) begin q_data.push_back(dout); q_last.push_back(dout_l); end
    if (din_v && din_rdy) in_cnt++;
    if (err) err_cnt++;
    if (dn) done_cnt++;
    if (w_dout_v && w_dout_rdy) begin w_data.push_back(w_dout); w_last.push_back(w_dout_l); end
    if (w_err) w_err_cnt++;
    if (w_dn) w_done_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input logic [LW-1:0] size, input logic [1:0] sch, input logic lst);
    int n = 0;
    csize = size; cscheme = sch; clast = lst; cv = 1'b1;
    @(negedge clk);
    while (!crdy && n < 100) begin @(negedge clk); n++; end
    if (!crdy) to_flag = 1;
    step();
    cv = 1'b0;
  endtask

  task automatic do_in(input logic [BW-1:0] d, input logic lst);
    int n = 0;
    din = d; din_l = lst; din_v = 1'b1;
    @(negedge clk);
    while (!din_rdy && n < 100) begin @(negedge clk); n++; end
    if (!din_rdy) to_flag = 1;
    step();
    din_v = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (q_data.size() < n && k < 200) begin step(); k++; end
    if (q_data.size() < n) to_flag = 1;
    repeat (3) step();
  endtask

  task automatic do_cfg_w(input logic [LW2-1:0] size, input logic [1:0] sch, input logic lst);
    int n = 0;
    w_csize = size; w_cscheme = sch; w_clast = lst; w_cv = 1'b1;
    @(negedge clk);
    while (!w_crdy && n < 100) begin @(negedge clk); n++; end
    if (!w_crdy) to_flag = 1;
    step();
    w_cv = 1'b0;
  endtask

  task automatic do_in_w(input logic [BW2-1:0] d, input logic lst);
    int n = 0;
    w_din = d; w_din_l = lst; w_din_v = 1'b1;
    @(negedge clk);
    while (!w_din_rdy && n < 100) begin @(negedge clk); n++; end
    if (!w_din_rdy) to_flag = 1;
    step();
    w_din_v = 1'b0;
  endtask

  task automatic wait_out_w(input int n);
    int k = 0;
    while (w_data.size() < n && k < 200) begin step(); k++; end
    if (w_data.size() < n) to_flag = 1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({dout_v, dout_l, din_rdy, crdy, err, dn} !== 6'b0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b ir=%b cr=%b e=%b d=%b dout_nz=%b want all 0",
               dout_v, dout_l, din_rdy, crdy, err, dn, |dout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (crdy !== 1'b1 || w_crdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_ready got %b/%b want 1/1", crdy, w_crdy);
    end
    step();
  endtask

  task automatic test_abc();
    logic [BW-1:0] d_abc, e_abc;
    int e0, d0;
    d_abc = {24'h616263, {488{1'b1}}};
    e_abc = {32'h61626380, 416'b0, 64'h18};
    q_data.delete(); q_last.delete();
    e0 = err_cnt; d0 = done_cnt;
    do_cfg(64'd24, 2'd0, 1'b1);
    do_in(d_abc, 1'b1);
    checks++;
    if (dout_v !== 1'b1) begin
      errors++;
      $display("FAIL abc_latency got valid=%b want 1", dout_v);
    end
    wait_out(1);
    checks++;
    if (q_data[0] !== e_abc || q_last[0] !== 1'b1 || q_data.size() != 1) begin
      errors++;
      $display("FAIL abc_block got %h last=%b n=%0d want %h last=1 n=1", q_data[0], q_last[0], q_data.size(), e_abc);
    end
    checks++;
    if (err_cnt - e0 != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL abc_pulses got err=%0d done=%0d want 0 1", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_len448();
    logic [BW-1:0] d, e1, e2;
    int d0;
    d  = {{14{32'hA5A55A5A}}, 64'hFFFF_FFFF_FFFF_FFFF};
    e1 = {{14{32'hA5A55A5A}}, 64'h8000_0000_0000_0000};
    e2 = {448'b0, 64'h1C0};
    q_data.delete(); q_last.delete();
    d0 = done_cnt;
    do_cfg(64'd448, 2'd2, 1'b0);
    do_in(d, 1'b1);
    wait_out(2);
    checks++;
    if (q_data[0] !== e1 || q_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL len448_blk1 got %h last=%b want %h last=0", q_data[0], q_last[0], e1);
    end
    checks++;
    if (q_data[1] !== e2 || q_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL len448_blk2 got %h last=%b want %h last=1", q_data[1], q_last[1], e2);
    end
    checks++;
    if (done_cnt - d0 != 0) begin
      errors++;
      $display("FAIL len448_done got %0d want 0", done_cnt - d0);
    end
  endtask

  task automatic test_len512_and_zero();
    logic [BW-1:0] d, e2, ez;
    int i0;
    d  = {16{32'hDEADBEEF}};
    e2 = {8'h80, 440'b0, 64'h200};
    ez = {8'h80, 504'b0};
    q_data.delete(); q_last.delete();
    do_cfg(64'd512, 2'd3, 1'b1);
    do_in(d, 1'b1);
    wait_out(2);
    checks++;
    if (q_data[0] !== d || q_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL len512_blk1 got %h last=%b want %h last=0", q_data[0], q_last[0], d);
    end
    checks++;
    if (q_data[1] !== e2 || q_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL len512_blk2 got %h last=%b want %h last=1", q_data[1], q_last[1], e2);
    end
    q_data.delete(); q_last.delete();
    din = d; din_l = 1'b1; din_v = 1'b1;
    i0 = in_cnt;
    do_cfg(64'd0, 2'd0, 1'b1);
    wait_out(1);
    din_v = 1'b0;
    checks++;
    if (q_data[0] !== ez || q_last[0] !== 1'b1 || q_data.size() != 1) begin
      errors++;
      $display("FAIL len0_block got %h last=%b n=%0d want %h last=1 n=1", q_data[0], q_last[0], q_data.size(), ez);
    end
    checks++;
    if (in_cnt - i0 != 0) begin
      errors++;
      $display("FAIL len0_consumed got %0d want 0", in_cnt - i0);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] b [3];
    logic [BW-1:0] e [4];
    logic          el [4];
    int e0, d0;
    b[0] = {16{32'h11111111}};
    b[1] = {16{32'h22222222}};
    b[2] = {16{32'h33333333}};
    e[0] = b[0]; e[1] = b[1]; e[2] = b[2];
    e[3] = {8'h80, 440'b0, 64'h600};
    el[0] = 1'b0; el[1] = 1'b0; el[2] = 1'b0; el[3] = 1'b1;
    q_data.delete(); q_last.delete();
    e0 = err_cnt; d0 = done_cnt;
    do_cfg(64'd1536, 2'd0, 1'b1);
    do_in(b[0], 1'b0);
    dout_rdy = 1'b0;
    din = b[1]; din_l = 1'b1; din_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (dout !== b[0] || dout_v !== 1'b1 || dout_l !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got %h v=%b l=%b want %h v=1 l=0", i, dout, dout_v, dout_l, b[0]);
      end
      checks++;
      if (din_rdy !== 1'b0 || crdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cyc%0d got in_rdy=%b cfg_rdy=%b want 0 0", i, din_rdy, crdy);
      end
    end
    step();
    dout_rdy = 1'b1;
    do_in(b[1], 1'b1);
    do_in(b[2], 1'b1);
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== e[i] || q_last[i] !== el[i]) begin
        errors++;
        $display("FAIL b2b_blk%0d got %h last=%b want %h last=%b", i, q_data[i], q_last[i], e[i], el[i]);
      end
    end
    checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 1 || q_data.size() != 4) begin
      errors++;
      $display("FAIL b2b_pulses got err=%0d done=%0d n=%0d want 1 1 4", err_cnt - e0, done_cnt - d0, q_data.size());
    end
  endtask

  task automatic test_reset_held();
    logic [BW-1:0] d_abc, e_abc;
    int n0, d0;
    d_abc = {24'h616263, {488{1'b1}}};
    e_abc = {32'h61626380, 416'b0, 64'h18};
    q_data.delete(); q_last.delete();
    dout_rdy = 1'b0;
    do_cfg(64'd24, 2'd0, 1'b1);
    do_in(d_abc, 1'b1);
    step();
    checks++;
    if (dout_v !== 1'b1) begin
      errors++;
      $display("FAIL rsthold_pre got valid=%b want 1", dout_v);
    end
    n0 = q_data.size(); d0 = done_cnt;
    rst = 1'b1;
    step();
    checks++;
    if (dout_v !== 1'b0 || dout_l !== 1'b0 || dout !== '0 || crdy !== 1'b0) begin
      errors++;
      $display("FAIL rsthold_clear got v=%b l=%b nz=%b cr=%b want 0 0 0 0", dout_v, dout_l, |dout, crdy);
    end
    rst = 1'b0;
    dout_rdy = 1'b1;
    step();
    checks++;
    if (q_data.size() != n0 || done_cnt != d0) begin
      errors++;
      $display("FAIL rsthold_nohs got n=%0d done=%0d want %0d %0d", q_data.size(), done_cnt, n0, d0);
    end
    do_cfg(64'd24, 2'd0, 1'b1);
    do_in(d_abc, 1'b1);
    wait_out(1);
    checks++;
    if (q_data[0] !== e_abc || q_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL rsthold_abc got %h last=%b want %h last=1", q_data[0], q_last[0], e_abc);
    end
  endtask

  task automatic test_wide();
    logic [BW2-1:0] d_abc, e_abc, a, b;
    int d0;
    d_abc = {24'h616263, {1000{1'b1}}};
    e_abc = {32'h61626380, 864'b0, 128'h18};
    w_data.delete(); w_last.delete();
    do_cfg_w(128'd24, 2'd0, 1'b1);
    do_in_w(d_abc, 1'b1);
    wait_out_w(1);
    checks++;
    if (w_data[0] !== e_abc || w_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL wide_abc got hi=%h lo=%h last=%b want hi=%h lo=%h last=1",
               w_data[0][1023:896], w_data[0][127:0], w_last[0], e_abc[1023:896], e_abc[127:0]);
    end
    a = {32{32'hCAFEF00D}};
    b = {32{32'h0BADC0DE}};
    w_data.delete(); w_last.delete();
    d0 = w_done_cnt;
    do_cfg_w(128'd1124, 2'd1, 1'b1);
    do_in_w(a, 1'b0);
    do_in_w(b, 1'b1);
    wait_out_w(2);
    repeat (5) step();
    checks++;
    if (w_data[0] !== a || w_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL wide_pass1 got hi=%h lo=%h last=%b want hi=%h lo=%h last=0",
               w_data[0][1023:896], w_data[0][127:0], w_last[0], a[1023:896], a[127:0]);
    end
    checks++;
    if (w_data[1] !== b || w_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL wide_pass2 got hi=%h lo=%h last=%b want hi=%h lo=%h last=1",
               w_data[1][1023:896], w_data[1][127:0], w_last[1], b[1023:896], b[127:0]);
    end
    checks++;
    if (w_data.size() != 2 || w_done_cnt - d0 != 1 || w_err_cnt != 0) begin
      errors++;
      $display("FAIL wide_pass_count got n=%0d done=%0d err=%0d want 2 1 0",
               w_data.size(), w_done_cnt - d0, w_err_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = '0; din_v = 1'b0; din_l = 1'b0;
    csize = '0; cscheme = '0; clast = 1'b0; cv = 1'b0; dout_rdy = 1'b1;
    w_din = '0; w_din_v = 1'b0; w_din_l = 1'b0;
    w_csize = '0; w_cscheme = '0; w_clast = 1'b0; w_cv = 1'b0; w_dout_rdy = 1'b1;
    test_reset();
    test_abc();
    test_len448();
    test_len512_and_zero();
    test_back_to_back();
    test_reset_held();
    test_wide();
    checks++;
    if (to_flag) begin
      errors++;
      $display("FAIL handshake_timeout got timeout=%b want 0", to_flag);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
